// File: rtl/axi_dma_wr.sv
// AXI4 write DMA: streams num_trans 32-bit words from a producer to DRAM as INCR bursts of up to FIXED_BURST_SIZE beats.
// Latency: AW is issued 2 cycles after start_dma; W data passes combinationally from producer to AXI with no added delay.
// Backpressure: M_WREADY feeds data_rdy_o directly; only one burst is outstanding, and the next AW waits for the previous B.
module axi_dma_wr #(
   parameter int BITS_TRANS       = 18,
   parameter int AXI_WIDTH_ID     = 4,
   parameter int AXI_WIDTH_AD     = 32,
   parameter int AXI_WIDTH_DA     = 32,
   parameter int AXI_WIDTH_DS     = AXI_WIDTH_DA / 8,
   parameter int FIXED_BURST_SIZE = 256
) (
   input  logic                    clk,
   input  logic                    rstn,
   // AXI write address channel
   output logic                    M_AWVALID,
   input  logic                    M_AWREADY,
   output logic [AXI_WIDTH_AD-1:0] M_AWADDR,
   output logic [AXI_WIDTH_ID-1:0] M_AWID,
   output logic [7:0]              M_AWLEN,
   output logic [2:0]              M_AWSIZE,
   output logic [1:0]              M_AWBURST,
   output logic [1:0]              M_AWLOCK,
   output logic [3:0]              M_AWCACHE,
   output logic [2:0]              M_AWPROT,
   output logic [3:0]              M_AWQOS,
   output logic [3:0]              M_AWREGION,
   output logic [3:0]              M_AWUSER,
   // AXI write data channel
   output logic                    M_WVALID,
   input  logic                    M_WREADY,
   output logic [AXI_WIDTH_DA-1:0] M_WDATA,
   output logic [AXI_WIDTH_DS-1:0] M_WSTRB,
   output logic                    M_WLAST,
   output logic [3:0]              M_WUSER,
   // AXI write response channel
   input  logic                    M_BVALID,
   output logic                    M_BREADY,
   input  logic [1:0]              M_BRESP,
   input  logic [AXI_WIDTH_ID-1:0] M_BID,
   // control and producer side
   input  logic                    start_dma,
   input  logic [BITS_TRANS-1:0]   num_trans,
   input  logic [AXI_WIDTH_AD-1:0] start_addr,
   input  logic [AXI_WIDTH_DA-1:0] data_i,
   input  logic                    data_vld_i,
   output logic                    data_rdy_o,
   output logic [BITS_TRANS-1:0]   data_cnt_o,
   output logic                    busy_o,
   output logic                    err_o,
   output logic                    done_o
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] PRE  = 3'd1;
   localparam logic [2:0] ADDR = 3'd2;
   localparam logic [2:0] DATA = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   localparam logic [8:0]            BURST_LEN = 9'(FIXED_BURST_SIZE);
   localparam logic [BITS_TRANS-1:0] BURST_TR  = BITS_TRANS'(FIXED_BURST_SIZE);

   logic [2:0]              state_q, state_d;
   logic [BITS_TRANS-1:0]   n_q, n_d;
   logic [BITS_TRANS-1:0]   sent_q, sent_d;
   logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
   logic [8:0]              len_q, len_d;
   logic [8:0]              beat_q, beat_d;
   logic [BITS_TRANS-1:0]   cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic                    done_q, done_d;

   logic [BITS_TRANS-1:0]   remain;
   logic [8:0]              len_m1;
   logic                    in_data;
   logic                    w_hs;
   logic                    last_beat;
   logic                    unused_ok;

   // BID is not checked (single outstanding burst) and the low address bits are forced to word alignment
   assign unused_ok = ^{M_BID, start_addr[1:0]};

   assign remain    = n_q - sent_q;
   assign len_m1    = len_q - 9'd1;
   assign in_data   = (state_q == DATA);
   assign w_hs      = in_data & data_vld_i & M_WREADY;
   assign last_beat = (beat_q == len_m1);

   // AW channel: held stable from state registers until the slave accepts
   assign M_AWVALID  = (state_q == ADDR);
   assign M_AWADDR   = addr_q;
   assign M_AWID     = '0;
   assign M_AWLEN    = M_AWVALID ? len_m1[7:0] : 8'd0;
   assign M_AWSIZE   = M_AWVALID ? 3'b010 : 3'b000;
   assign M_AWBURST  = M_AWVALID ? 2'b01 : 2'b00;
   assign M_AWLOCK   = '0;
   assign M_AWCACHE  = '0;
   assign M_AWPROT   = '0;
   assign M_AWQOS    = 4'hF;
   assign M_AWREGION = '0;
   assign M_AWUSER   = '0;

   // W channel: producer handshake passes straight through while a burst is open
   assign M_WVALID   = in_data & data_vld_i;
   assign M_WDATA    = data_i;
   assign M_WSTRB    = '1;
   assign M_WLAST    = in_data & last_beat;
   assign M_WUSER    = '0;
   assign data_rdy_o = in_data & M_WREADY;

   assign M_BREADY   = (state_q == RESP);

   assign data_cnt_o = cnt_q;
   assign busy_o     = (state_q != IDLE);
   assign err_o      = err_q;
   assign done_o     = done_q;

   // Next-state logic: burst sequencing, beat counting and response bookkeeping
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      sent_d  = sent_q;
      addr_d  = addr_q;
      len_d   = len_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_dma) begin
               n_d     = num_trans;
               addr_d  = {start_addr[AXI_WIDTH_AD-1:2], 2'b00};
               sent_d  = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = PRE;
            end
         end
         PRE: begin
            if (sent_q == n_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               len_d   = (remain >= BURST_TR) ? BURST_LEN : remain[8:0];
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (M_AWREADY) state_d = DATA;
         end
         DATA: begin
            if (w_hs) begin
               cnt_d = cnt_q + 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = RESP;
               end else begin
                  beat_d = beat_q + 9'd1;
               end
            end
         end
         RESP: begin
            if (M_BVALID) begin
               addr_d  = addr_q + AXI_WIDTH_AD'({len_q, 2'b00});
               sent_d  = sent_q + BITS_TRANS'(len_q);
               // data is already consumed, so an error response is only flagged, never retried
               if (M_BRESP != 2'b00) err_d = 1'b1;
               state_d = PRE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         n_q     <= '0;
         sent_q  <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         sent_q  <= sent_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_axi_dma_wr.sv
// Bench for axi_dma_wr: directed transfers with a scoreboard of expected AW, W and done events.
// Stimulus drives inputs 1ns after the rising edge; the monitor samples on the falling edge.
// A small slave model answers AW/W/B with optional stalls, throttling and error responses.
module tb_axi_dma_wr;

   localparam int BT = 18;

   logic          clk;
   logic          rstn;
   logic          M_AWVALID, M_AWREADY;
   logic [31:0]   M_AWADDR;
   logic [3:0]    M_AWID;
   logic [7:0]    M_AWLEN;
   logic [2:0]    M_AWSIZE;
   logic [1:0]    M_AWBURST, M_AWLOCK;
   logic [3:0]    M_AWCACHE;
   logic [2:0]    M_AWPROT;
   logic [3:0]    M_AWQOS, M_AWREGION, M_AWUSER;
   logic          M_WVALID, M_WREADY;
   logic [31:0]   M_WDATA;
   logic [3:0]    M_WSTRB;
   logic          M_WLAST;
   logic [3:0]    M_WUSER;
   logic          M_BVALID, M_BREADY;
   logic [1:0]    M_BRESP;
   logic [3:0]    M_BID;
   logic          start_dma;
   logic [BT-1:0] num_trans;
   logic [31:0]   start_addr;
   logic [31:0]   data_i;
   logic          data_vld_i, data_rdy_o;
   logic [BT-1:0] data_cnt_o;
   logic          busy_o, err_o, done_o;

   axi_dma_wr dut (
      .clk(clk), .rstn(rstn),
      .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWID(M_AWID),
      .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK),
      .M_AWCACHE(M_AWCACHE), .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS), .M_AWREGION(M_AWREGION),
      .M_AWUSER(M_AWUSER),
      .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
      .M_WLAST(M_WLAST), .M_WUSER(M_WUSER),
      .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP), .M_BID(M_BID),
      .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr),
      .data_i(data_i), .data_vld_i(data_vld_i), .data_rdy_o(data_rdy_o),
      .data_cnt_o(data_cnt_o), .busy_o(busy_o), .err_o(err_o), .done_o(done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
   typedef struct packed { logic [31:0] data; logic last; } w_t;
   typedef struct packed { logic err; logic [BT-1:0] cnt; } done_t;

   aw_t   aw_q[$];
   w_t    w_q[$];
   done_t done_q[$];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_evt = 0;
   int          done_seen = 0;
   int          widx = 0;
   int          aw_stall = 0;
   int          burst_idx = 0;
   int          bad_burst = -1;
   bit          rnd_en = 1'b0;
   bit          b_pending = 1'b0;
   logic [1:0]  b_resp_v = 2'b00;
   logic [31:0] data_base = 32'h0;

   // monitor state
   logic        aw_pend = 1'b0;
   logic [31:0] aw_addr_p = 32'h0;
   logic [7:0]  aw_len_p = 8'h0;
   logic        err_model = 1'b0;
   int          aw_cnt = 0;
   int          wl_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_aw(input logic [31:0] addr, input logic [7:0] len);
      aw_t a;
      a.addr = addr;
      a.len  = len;
      aw_q.push_back(a);
   endtask

   task automatic push_w(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         w_t w;
         w.data = base + i;
         w.last = ((i % 256) == 255) || (i == n - 1);
         w_q.push_back(w);
      end
   endtask

   task automatic push_done(input logic err, input logic [BT-1:0] cnt);
      done_t d;
      d.err = err;
      d.cnt = cnt;
      done_q.push_back(d);
   endtask

   task automatic start_xfer(input int n, input logic [31:0] addr, input logic [31:0] base);
      data_base = base;
      widx      = 0;
      burst_idx = 0;
      @(posedge clk); #1;
      num_trans  = BT'(n);
      start_addr = addr;
      start_dma  = 1'b1;
      @(posedge clk); #1;
      start_dma  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0);
      for (int k = 0; k < 5000 && done_seen == d0; k++) @(negedge clk);
      chk({name, "_done_seen"}, 64'(done_seen != d0), 64'd1);
      repeat (3) @(negedge clk);
      chk({name, "_aw_left"}, 64'(aw_q.size()), 64'd0);
      chk({name, "_w_left"}, 64'(w_q.size()), 64'd0);
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_awvalid"}, 64'(M_AWVALID), 64'd0);
      chk({name, "_wvalid"}, 64'(M_WVALID), 64'd0);
      chk({name, "_rdy"}, 64'(data_rdy_o), 64'd0);
      chk({name, "_bready"}, 64'(M_BREADY), 64'd0);
      chk({name, "_busy"}, 64'(busy_o), 64'd0);
      chk({name, "_done"}, 64'(done_o), 64'd0);
      chk({name, "_err"}, 64'(err_o), 64'd0);
      chk({name, "_cnt"}, 64'(data_cnt_o), 64'd0);
   endtask

   // Slave and producer model: samples handshakes on the falling edge, drives after the rising edge
   initial begin
      M_AWREADY  = 1'b1;
      M_WREADY   = 1'b1;
      M_BVALID   = 1'b0;
      M_BRESP    = 2'b00;
      M_BID      = 4'h0;
      data_vld_i = 1'b0;
      data_i     = 32'h0;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (M_WVALID && M_WREADY) begin
               widx++;
               if (M_WLAST) begin
                  b_pending = 1'b1;
                  b_resp_v  = (burst_idx == bad_burst) ? 2'b10 : 2'b00;
                  burst_idx++;
               end
            end
            if (M_BVALID && M_BREADY) b_pending = 1'b0;
            if (M_AWVALID && aw_stall > 0) aw_stall--;
         end
         @(posedge clk); #1;
         M_AWREADY  = (aw_stall == 0);
         M_WREADY   = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         data_vld_i = rnd_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         data_i     = data_base + widx;
         M_BVALID   = b_pending;
         M_BRESP    = b_pending ? b_resp_v : 2'b00;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a handshake or completion
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rstn) begin
            aw_pend   = 1'b0;
            err_model = 1'b0;
            aw_cnt    = 0;
            wl_cnt    = 0;
         end else begin
            if (aw_pend)
               chk("aw_hold", {23'd0, M_AWVALID, M_AWADDR, M_AWLEN}, {23'd0, 1'b1, aw_addr_p, aw_len_p});
            if (M_AWVALID && M_AWREADY) begin
               chk("aw_expected", 64'(aw_q.size() != 0), 64'd1);
               if (aw_q.size() != 0) begin
                  aw_t a;
                  a = aw_q.pop_front();
                  chk("aw_addr", 64'(M_AWADDR), 64'(a.addr));
                  chk("aw_len", 64'(M_AWLEN), 64'(a.len));
                  chk("aw_size_burst", 64'({M_AWSIZE, M_AWBURST}), 64'({3'b010, 2'b01}));
               end
               aw_cnt++;
            end
            aw_pend   = M_AWVALID && !M_AWREADY;
            aw_addr_p = M_AWADDR;
            aw_len_p  = M_AWLEN;
            if (M_WVALID && M_WREADY) begin
               chk("w_after_aw", 64'(aw_cnt), 64'(wl_cnt + 1));
               chk("w_expected", 64'(w_q.size() != 0), 64'd1);
               if (w_q.size() != 0) begin
                  w_t w;
                  w = w_q.pop_front();
                  chk("w_data", 64'(M_WDATA), 64'(w.data));
                  chk("w_last", 64'(M_WLAST), 64'(w.last));
               end
               if (M_WLAST) wl_cnt++;
            end
            chk("err_sticky", 64'(err_o), 64'(err_model));
            if (done_o) begin
               chk("done_expected", 64'(done_q.size() != 0), 64'd1);
               if (done_q.size() != 0) begin
                  done_t d;
                  d = done_q.pop_front();
                  chk("done_err", 64'(err_o), 64'(d.err));
                  chk("done_cnt", 64'(data_cnt_o), 64'(d.cnt));
                  chk("done_delay", 64'(cyc - last_evt), 64'd2);
                  chk("done_busy", 64'(busy_o), 64'd0);
               end
               done_seen++;
            end
            if (start_dma && !busy_o) begin
               err_model = 1'b0;
               last_evt  = cyc;
            end
            if (M_BVALID && M_BREADY) begin
               if (M_BRESP != 2'b00) err_model = 1'b1;
               last_evt = cyc;
            end
         end
      end
   end

   // Directed test sequence
   initial begin
      int d0;
      rstn       = 1'b0;
      start_dma  = 1'b0;
      num_trans  = '0;
      start_addr = 32'h0;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      chk_reset("reset");

      // 600 words: two full bursts and an 88-beat tail
      push_aw(32'h1000_0000, 8'd255);
      push_aw(32'h1000_0400, 8'd255);
      push_aw(32'h1000_0800, 8'd87);
      push_w(600, 32'hA000_0000);
      push_done(1'b0, BT'(600));
      d0 = done_seen;
      start_xfer(600, 32'h1000_0000, 32'hA000_0000);
      wait_done("t600", d0);

      // zero-length transfer: only a done pulse
      push_done(1'b0, BT'(0));
      d0 = done_seen;
      start_xfer(0, 32'h1800_0000, 32'h0);
      wait_done("t0", d0);

      // one full burst with AWREADY held low for 10 cycles
      aw_stall = 10;
      push_aw(32'h2000_0000, 8'd255);
      push_w(256, 32'hB000_0000);
      push_done(1'b0, BT'(256));
      d0 = done_seen;
      start_xfer(256, 32'h2000_0000, 32'hB000_0000);
      wait_done("t256_stall", d0);

      // 300 words with random producer and WREADY throttling
      rnd_en = 1'b1;
      push_aw(32'h3000_0000, 8'd255);
      push_aw(32'h3000_0400, 8'd43);
      push_w(300, 32'hC000_0000);
      push_done(1'b0, BT'(300));
      d0 = done_seen;
      start_xfer(300, 32'h3000_0000, 32'hC000_0000);
      wait_done("t300_rnd", d0);
      rnd_en = 1'b0;

      // 512 words, first burst answered with SLVERR
      bad_burst = 0;
      push_aw(32'h4000_0000, 8'd255);
      push_aw(32'h4000_0400, 8'd255);
      push_w(512, 32'hD000_0000);
      push_done(1'b1, BT'(512));
      d0 = done_seen;
      start_xfer(512, 32'h4000_0000, 32'hD000_0000);
      wait_done("t512_err", d0);
      bad_burst = -1;

      // reset in the middle of a burst, then a short transfer
      push_aw(32'h5000_0000, 8'd255);
      push_w(256, 32'hE000_0000);
      start_xfer(256, 32'h5000_0000, 32'hE000_0000);
      for (int k = 0; k < 2000 && widx < 100; k++) @(negedge clk);
      chk("mid_reset_reached_beat100", 64'(widx >= 100), 64'd1);
      @(posedge clk); #2;
      rstn = 1'b0;
      @(negedge clk);
      chk_reset("mid_reset");
      aw_q.delete();
      w_q.delete();
      b_pending = 1'b0;
      widx      = 0;
      burst_idx = 0;
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      push_aw(32'h6000_0000, 8'd3);
      push_w(4, 32'hF000_0000);
      push_done(1'b0, BT'(4));
      d0 = done_seen;
      start_xfer(4, 32'h6000_0000, 32'hF000_0000);
      wait_done("t4_after_reset", d0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
